// File: rtl/uart_apb_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_sched
// Purpose  : APB master that initialises a UART register block after reset,
//            then schedules runtime accesses: two round-robin transmit
//            requesters share THR, an optional receive poller drains RBR.
//            THR is only written after an LSR read that reported THRE=1.
// Ports    : sys_clk/sys_rst       - clock, synchronous active-high reset
//            paddr/psel/penable/pwrite/pwdata/prdata - APB master port
//            tx_req*/tx_data*/tx_ack* - transmit requesters (ack = pulse)
//            rx_en/rx_vld/rx_data  - receive draining and delivered byte
//            err_vld/err_flags     - {FE,PE,OE} seen in an LSR read
//            init_done             - register init sequence complete
// Revision : 1.0 - initial release
// ============================================================================
module uart_apb_sched #(
    parameter logic [7:0] LCR_INIT = 8'h03,
    parameter logic [7:0] DLL_INIT = 8'h1B,
    parameter logic [7:0] DLH_INIT = 8'h00,
    parameter logic [7:0] IER_INIT = 8'h00
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        tx_req0,
    input  logic        tx_req1,
    input  logic [7:0]  tx_data0,
    input  logic [7:0]  tx_data1,
    output logic        tx_ack0,
    output logic        tx_ack1,
    input  logic        rx_en,
    output logic        rx_vld,
    output logic [7:0]  rx_data,
    output logic        err_vld,
    output logic [2:0]  err_flags,
    output logic        init_done
);

    localparam logic [3:0] c_init_usr      = 4'd0;
    localparam logic [3:0] c_init_lcr_dlab = 4'd1;
    localparam logic [3:0] c_init_dll      = 4'd2;
    localparam logic [3:0] c_init_dlh      = 4'd3;
    localparam logic [3:0] c_init_lcr      = 4'd4;
    localparam logic [3:0] c_init_ier      = 4'd5;
    localparam logic [3:0] c_idle          = 4'd6;
    localparam logic [3:0] c_poll_lsr      = 4'd7;
    localparam logic [3:0] c_rd_rbr        = 4'd8;
    localparam logic [3:0] c_wr_thr        = 4'd9;

    localparam logic [31:0] c_addr_thr = 32'h0000_0000;  // also RBR, DLL
    localparam logic [31:0] c_addr_ier = 32'h0000_0004;  // also DLH
    localparam logic [31:0] c_addr_lcr = 32'h0000_000C;
    localparam logic [31:0] c_addr_lsr = 32'h0000_0014;
    localparam logic [31:0] c_addr_usr = 32'h0000_007C;

    // r_state names the transfer in flight (or about to start); psel/penable
    // tell which phase of it the bus is in.
    logic [3:0]  r_state;
    logic        r_last;   // requester granted by the last completed THR write
    logic        r_gnt;    // grant latched during the LSR poll

    logic [3:0]  w_nxt;
    logic        w_start;
    logic        w_to_access;
    logic        w_access_end;
    logic        w_tx_pend;
    logic        w_gnt;
    logic [31:0] w_addr;
    logic        w_write;
    logic [7:0]  w_wbyte;
    logic        w_unused_ok;

    assign w_access_end = psel & penable;
    assign w_tx_pend    = tx_req0 | tx_req1;
    // On a tie the requester that did not win last time goes next.
    assign w_gnt        = (tx_req0 & tx_req1) ? ~r_last : tx_req1;
    assign w_unused_ok  = ^prdata[31:8];

    // Sequencing: decide which transfer (if any) starts in the next cycle.
    always_comb begin
        w_nxt       = r_state;
        w_start     = 1'b0;
        w_to_access = 1'b0;
        if (!psel) begin
            if (r_state == c_idle) begin
                if (w_tx_pend | rx_en) begin
                    w_nxt   = c_poll_lsr;
                    w_start = 1'b1;
                end
            end else begin
                // First transfer after reset: state is parked, bus is quiet.
                w_start = 1'b1;
            end
        end else if (!penable) begin
            w_to_access = 1'b1;
        end else begin
            case (r_state)
                c_init_usr: begin
                    w_start = 1'b1;
                    if (!prdata[0]) begin
                        w_nxt = c_init_lcr_dlab;
                    end
                end
                c_init_lcr_dlab: begin w_nxt = c_init_dll; w_start = 1'b1; end
                c_init_dll:      begin w_nxt = c_init_dlh; w_start = 1'b1; end
                c_init_dlh:      begin w_nxt = c_init_lcr; w_start = 1'b1; end
                c_init_lcr:      begin w_nxt = c_init_ier; w_start = 1'b1; end
                c_poll_lsr: begin
                    if (rx_en && prdata[0]) begin
                        w_nxt   = c_rd_rbr;
                        w_start = 1'b1;
                    end else if (w_tx_pend && prdata[5]) begin
                        w_nxt   = c_wr_thr;
                        w_start = 1'b1;
                    end else begin
                        w_nxt = c_idle;
                    end
                end
                default: w_nxt = c_idle;
            endcase
        end
    end

    // Address/direction/data of the transfer about to be set up.
    always_comb begin
        w_addr  = c_addr_thr;
        w_write = 1'b0;
        w_wbyte = 8'h00;
        case (w_nxt)
            c_init_usr: w_addr = c_addr_usr;
            c_init_lcr_dlab: begin
                w_addr  = c_addr_lcr;
                w_write = 1'b1;
                w_wbyte = {1'b1, 2'b00, LCR_INIT[4:0]};
            end
            c_init_dll: begin
                w_write = 1'b1;
                w_wbyte = DLL_INIT;
            end
            c_init_dlh: begin
                w_addr  = c_addr_ier;
                w_write = 1'b1;
                w_wbyte = DLH_INIT;
            end
            c_init_lcr: begin
                w_addr  = c_addr_lcr;
                w_write = 1'b1;
                w_wbyte = {3'b000, LCR_INIT[4:0]};
            end
            c_init_ier: begin
                w_addr  = c_addr_ier;
                w_write = 1'b1;
                w_wbyte = {4'h0, IER_INIT[3:0]};
            end
            c_poll_lsr: w_addr = c_addr_lsr;
            c_wr_thr: begin
                // Only entered straight from the poll, so the live grant is
                // the one being latched on this same edge.
                w_write = 1'b1;
                w_wbyte = w_gnt ? tx_data1 : tx_data0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= c_init_usr;
            r_last    <= 1'b1;
            r_gnt     <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= 32'h0;
            pwdata    <= 32'h0;
            tx_ack0   <= 1'b0;
            tx_ack1   <= 1'b0;
            rx_vld    <= 1'b0;
            rx_data   <= 8'h00;
            err_vld   <= 1'b0;
            err_flags <= 3'b000;
            init_done <= 1'b0;
        end else begin
            r_state <= w_nxt;
            tx_ack0 <= 1'b0;
            tx_ack1 <= 1'b0;
            rx_vld  <= 1'b0;
            err_vld <= 1'b0;

            if (w_start) begin
                psel    <= 1'b1;
                penable <= 1'b0;
                pwrite  <= w_write;
                paddr   <= w_addr;
                pwdata  <= {24'h0, w_wbyte};
            end else if (w_to_access) begin
                penable <= 1'b1;
            end else begin
                psel    <= 1'b0;
                penable <= 1'b0;
                pwrite  <= 1'b0;
                paddr   <= 32'h0;
                pwdata  <= 32'h0;
            end

            if (w_access_end) begin
                case (r_state)
                    c_init_ier: init_done <= 1'b1;
                    c_poll_lsr: begin
                        r_gnt <= w_gnt;
                        if (prdata[3:1] != 3'b000) begin
                            err_vld   <= 1'b1;
                            err_flags <= prdata[3:1];
                        end
                    end
                    c_rd_rbr: begin
                        rx_vld  <= 1'b1;
                        rx_data <= prdata[7:0];
                    end
                    c_wr_thr: begin
                        tx_ack0 <= ~r_gnt;
                        tx_ack1 <= r_gnt;
                        r_last  <= r_gnt;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
